// File: rtl/jtag_debug_sysclk_cmdq.sv
// -----------------------------------------------------------------------------
// jtag_debug_sysclk_cmdq
//
// System-clock side of the JTAG debug bridge. The virtual-JTAG update-DR and
// update-IR levels arrive from the tck domain. They are synchronised into clk
// and turned into single-cycle rising-edge events. Each update-DR captures
// {ir_in, sr} into a small command queue. A debug consumer drains the queue
// with a ready handshake. Each pop loads jdo/jdo_ir and fires a one-hot
// take_action or take_no_action pulse, indexed by the command's IR code.
//
// Ports:
//   clk, reset_n    system clock, asynchronous active-low reset
//   vs_udr, vs_uir  update-DR / update-IR levels (tck domain, async)
//   ir_in, sr       virtual IR and scan register, stable while strobes high
//   cmd_ready       consumer accepts the next queued command
//   clr_overflow    synchronous clear of the sticky overflow flag
//   jdo, jdo_ir     data / IR of the most recently popped command
//   take_action     one-hot pulse per pop when jdo[ACT_BIT] = 1
//   take_no_action  one-hot pulse per pop when jdo[ACT_BIT] = 0
//   ir_update       one-cycle pulse per synchronised update-IR
//   cmd_pending     queue not empty
//   fifo_level      queue occupancy, 0..FIFO_DEPTH
//   overflow        sticky, set when a capture was dropped on a full queue
// -----------------------------------------------------------------------------
module jtag_debug_sysclk_cmdq #(
  parameter int unsigned DATA_W      = 38,
  parameter int unsigned IR_W        = 2,
  parameter int unsigned ACT_BIT     = 35,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  localparam int unsigned NCMD       = 2**IR_W,
  localparam int unsigned AW         = $clog2(FIFO_DEPTH),
  localparam int unsigned LW         = AW + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vs_udr,
  input  logic              vs_uir,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [DATA_W-1:0] sr,
  input  logic              cmd_ready,
  input  logic              clr_overflow,
  output logic [DATA_W-1:0] jdo,
  output logic [IR_W-1:0]   jdo_ir,
  output logic [NCMD-1:0]   take_action,
  output logic [NCMD-1:0]   take_no_action,
  output logic              ir_update,
  output logic              cmd_pending,
  output logic [LW-1:0]     fifo_level,
  output logic              overflow
);

  localparam int unsigned EW = IR_W + DATA_W;

  // Synchronisers and edge detection
  logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
  logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
  // Tracks that the sync chains hold real samples, not reset zeros.
  logic [SYNC_STAGES-1:0] sample_vld_q, sample_vld_d;
  logic                   udr_s_d_q, udr_s_d_d;
  logic                   uir_s_d_q, uir_s_d_d;
  logic                   udr_arm_q, udr_arm_d;
  logic                   uir_arm_q, uir_arm_d;
  logic                   udr_s, uir_s;
  logic                   udr_rise, uir_rise;

  // Command queue
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [EW-1:0]          mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          count_q, count_d;
  logic [EW-1:0]          head;
  logic [IR_W-1:0]        head_ir;
  logic [DATA_W-1:0]      head_data;
  logic                   full, pop, push_ok, drop;

  // Registered outputs
  logic [DATA_W-1:0]      jdo_q, jdo_d;
  logic [IR_W-1:0]        jdo_ir_q, jdo_ir_d;
  logic [NCMD-1:0]        take_action_q, take_action_d;
  logic [NCMD-1:0]        take_no_action_q, take_no_action_d;
  logic                   ir_update_q, ir_update_d;
  logic                   overflow_q, overflow_d;

  always_comb begin
    udr_sync_d   = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
    uir_sync_d   = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
    sample_vld_d = {sample_vld_q[SYNC_STAGES-2:0], 1'b1};

    udr_s = udr_sync_q[SYNC_STAGES-1];
    uir_s = uir_sync_q[SYNC_STAGES-1];

    udr_s_d_d = udr_s;
    uir_s_d_d = uir_s;

    // Arm only after a genuine low sample has come through the chain. A
    // strobe that is already high at reset release is then never seen as a
    // rising edge.
    udr_arm_d = udr_arm_q | (sample_vld_q[SYNC_STAGES-1] & ~udr_s);
    uir_arm_d = uir_arm_q | (sample_vld_q[SYNC_STAGES-1] & ~uir_s);

    udr_rise = udr_s & ~udr_s_d_q & udr_arm_q;
    uir_rise = uir_s & ~uir_s_d_q & uir_arm_q;

    ir_update_d = uir_rise;
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    head_ir   = head[EW-1:DATA_W];
    head_data = head[DATA_W-1:0];

    full    = (count_q == LW'(FIFO_DEPTH));
    pop     = (count_q != '0) & cmd_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    push_ok = udr_rise & (~full | pop);
    drop    = udr_rise & full & ~pop;

    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = {ir_in, sr};

    wr_ptr_d = wr_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);

    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase

    jdo_d            = jdo_q;
    jdo_ir_d         = jdo_ir_q;
    take_action_d    = '0;
    take_no_action_d = '0;
    if (pop) begin
      jdo_d    = head_data;
      jdo_ir_d = head_ir;
      if (head_data[ACT_BIT]) take_action_d[head_ir]    = 1'b1;
      else                    take_no_action_d[head_ir] = 1'b1;
    end

    // A drop takes priority over a same-cycle clear.
    overflow_d = overflow_q;
    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync_q       <= '0;
      uir_sync_q       <= '0;
      sample_vld_q     <= '0;
      udr_s_d_q        <= 1'b0;
      uir_s_d_q        <= 1'b0;
      udr_arm_q        <= 1'b0;
      uir_arm_q        <= 1'b0;
      mem_q            <= '{default: '0};
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      jdo_q            <= '0;
      jdo_ir_q         <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      ir_update_q      <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      udr_sync_q       <= udr_sync_d;
      uir_sync_q       <= uir_sync_d;
      sample_vld_q     <= sample_vld_d;
      udr_s_d_q        <= udr_s_d_d;
      uir_s_d_q        <= uir_s_d_d;
      udr_arm_q        <= udr_arm_d;
      uir_arm_q        <= uir_arm_d;
      mem_q            <= mem_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      jdo_q            <= jdo_d;
      jdo_ir_q         <= jdo_ir_d;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      ir_update_q      <= ir_update_d;
      overflow_q       <= overflow_d;
    end
  end

  assign jdo            = jdo_q;
  assign jdo_ir         = jdo_ir_q;
  assign take_action    = take_action_q;
  assign take_no_action = take_no_action_q;
  assign ir_update      = ir_update_q;
  assign cmd_pending    = (count_q != '0);
  assign fifo_level     = count_q;
  assign overflow       = overflow_q;

endmodule

// File: doc/jtag_debug_sysclk_cmdq.md
Name: jtag_debug_sysclk_cmdq

Overview:
- System-clock side of the Nios II JTAG debug bridge, parametrised for data-register width, IR width and command queue depth.
- Synchronises the virtual-JTAG update-DR and update-IR strobes into clk and captures the scan register with its IR on each update-DR.
- Queues captured commands in a FIFO so that a busy debug consumer (OCI memory, break or trace logic) does not lose back-to-back scans.
- Pops commands under a ready handshake onto jdo and emits a one-hot take_action or take_no_action pulse per IR code.

Parameters:
- DATA_W, 38: scan register / jdo width.
- IR_W, 2: virtual IR width; decode width is NCMD = 2**IR_W.
- ACT_BIT, 35: jdo bit that selects take_action (1) or take_no_action (0); must be < DATA_W.
- SYNC_STAGES, 2: synchroniser depth, ≥2.
- FIFO_DEPTH, 4: command queue entries; power of 2, ≥2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- vs_udr  in  1  virtual update-DR level, tck domain, asynchronous to clk
- vs_uir  in  1  virtual update-IR level, tck domain, asynchronous to clk
- ir_in  in  IR_W  virtual IR; quasi-static while vs_udr/vs_uir is high
- sr  in  DATA_W  scan shift register; quasi-static while vs_udr is high
- cmd_ready  in  1  consumer can accept the next command
- clr_overflow  in  1  synchronous clear of overflow
- jdo  out  DATA_W  data of the last popped command
- jdo_ir  out  IR_W  IR of the last popped command
- take_action  out  NCMD  one-hot pulse, aligned with jdo update
- take_no_action  out  NCMD  one-hot pulse, aligned with jdo update
- ir_update  out  1  one-cycle pulse on each synchronised update-IR
- cmd_pending  out  1  FIFO not empty
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset: every flop, including sync chains, FIFO pointers and arm flags, clears to 0. All outputs are 0 during reset.
- Synchronisers:
  - vs_udr and vs_uir each pass through SYNC_STAGES flops; udr_s is the last stage.
  - udr_rise = udr_s & ~udr_s_d & udr_arm.
  - udr_arm sets on the first cycle udr_s is observed 0 after reset. A strobe held high across reset release therefore pushes nothing. vs_uir is handled identically.
- Push: on the udr_rise cycle, {ir_in, sr} is written to the FIFO. The first rising vs_udr sample reaches the FIFO SYNC_STAGES+1 clk cycles later.
- ir_update: registered pulse the cycle after uir_rise. ir_in is not queued on update-IR.
- Pop: occurs when cmd_pending & cmd_ready. The next cycle:
  - jdo and jdo_ir load the head entry;
  - exactly one bit [head ir] of take_action (if data[ACT_BIT]=1) or of take_no_action (if 0) pulses for one cycle.
  - All other decode bits are 0. jdo and jdo_ir hold until the next pop.
- Back-to-back: with cmd_ready held high, one pop per cycle and one pulse per cycle, with no bubble.
- Pop on empty: ignored; no pulse.
- Full: a push while the FIFO is full and there is no pop is dropped, sets overflow, and leaves contents unchanged.
  - Push and pop in the same cycle while full: both occur, level is unchanged, nothing is dropped.
  - Push and pop while empty: the push is stored; no pop occurs that cycle.
- Overflow:
  - clr_overflow clears it.
  - If a drop and clr_overflow occur in the same cycle, the set wins.
- Pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH.
- Reset mid-operation: queued commands are discarded, pulses are aborted, and jdo returns to 0.

Test Plan:
- Single scan: ir_in=2, sr=38'h08_0000_1234 (bit35=1), vs_udr high 8 clks, cmd_ready=1 -> take_action=4'b0100 one cycle, jdo=38'h08_0000_1234, jdo_ir=2; take_no_action stays 0.
- No-action decode: ir_in=0, sr bit35=0, sr=38'h0_0000_00AA -> take_no_action=4'b0001 one pulse; jdo=38'h0_0000_00AA.
- Backpressure/overflow: cmd_ready=0, 5 scans (FIFO_DEPTH=4) -> fifo_level=4, overflow=1. Then cmd_ready=1 -> 4 consecutive pulses in push order, the 5th scan absent, level returns to 0.
- Full plus simultaneous push/pop: hold FIFO at 4 with cmd_ready pulsed on the push cycle -> level stays 4, overflow stays 0.
- Reset edges: vs_udr high through reset release -> no push. Assert reset_n=0 with 3 queued -> level=0, jdo=0, no pulses after release.
- ir_update and overflow clear: toggle vs_uir -> ir_update exactly one pulse, SYNC_STAGES+1 cycles after the first high sample. Drop and clr_overflow in the same cycle -> overflow=1; clr_overflow alone -> 0.
